// File: rtl/mux_sel_sequencer.sv
// Serialiser front end for an 8:1 mux. It holds a handshaken word on i and steps s through every slot.
// Define MUX_SEQ_MSB_FIRST_EN to walk s from 7 down to 0. The default order is 0 up to 7.
module mux_sel_sequencer #(
  parameter int HOLD_CYC = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic [7:0] i,
  output logic [2:0] s,
  output logic       bit_valid,
  output logic       last,
  output logic       done
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYC - 1);

`ifdef MUX_SEQ_MSB_FIRST_EN
  localparam logic [2:0] S_START = 3'd7;
  localparam logic [2:0] S_END   = 3'd0;
`else
  localparam logic [2:0] S_START = 3'd0;
  localparam logic [2:0] S_END   = 3'd7;
`endif

  logic [0:0] state_reg;
  logic [7:0] hold_cnt_reg;
  logic [2:0] s_next;
  logic       slot_end;
  logic       final_cycle;
  logic       xfer;

`ifdef MUX_SEQ_MSB_FIRST_EN
  assign s_next = s - 3'd1;
`else
  assign s_next = s + 3'd1;
`endif

  assign slot_end    = (hold_cnt_reg == HOLD_LAST);
  assign final_cycle = (state_reg == RUN) && (s == S_END) && slot_end;
  assign din_ready   = (state_reg == IDLE) || final_cycle;
  assign xfer        = din_valid && din_ready;
  assign bit_valid   = (state_reg == RUN);
  assign last        = bit_valid && (s == S_END);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      hold_cnt_reg <= 8'd0;
      i            <= 8'h00;
      s            <= 3'd0;
      done         <= 1'b0;
    end else begin
      done <= final_cycle;
      if (xfer) begin
        // A transfer on the final cycle reloads in place, so back-to-back words stream without a gap.
        i            <= din;
        s            <= S_START;
        hold_cnt_reg <= 8'd0;
        state_reg    <= RUN;
      end else if (state_reg == RUN) begin
        if (slot_end) begin
          hold_cnt_reg <= 8'd0;
          if (s == S_END) begin
            state_reg <= IDLE;
          end else begin
            s <= s_next;
          end
        end else begin
          hold_cnt_reg <= hold_cnt_reg + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Directed bench for mux_sel_sequencer. Instance a runs with HOLD_CYC=1 and instance b with HOLD_CYC=3.
// The expected slot order follows MUX_SEQ_MSB_FIRST_EN, so the same bench checks both builds.
module tb_mux_sel_sequencer;

  logic       clk;
  logic       rst;
  logic [7:0] a_din, b_din;
  logic       a_din_valid, b_din_valid;
  logic       a_din_ready, b_din_ready;
  logic [7:0] a_i, b_i;
  logic [2:0] a_s, b_s;
  logic       a_bit_valid, b_bit_valid;
  logic       a_last, b_last;
  logic       a_done, b_done;

  int checks = 0;
  int errors = 0;

  mux_sel_sequencer #(.HOLD_CYC(1)) u_a (
    .clk(clk), .rst(rst), .din(a_din), .din_valid(a_din_valid), .din_ready(a_din_ready),
    .i(a_i), .s(a_s), .bit_valid(a_bit_valid), .last(a_last), .done(a_done)
  );

  mux_sel_sequencer #(.HOLD_CYC(3)) u_b (
    .clk(clk), .rst(rst), .din(b_din), .din_valid(b_din_valid), .din_ready(b_din_ready),
    .i(b_i), .s(b_s), .bit_valid(b_bit_valid), .last(b_last), .done(b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Select value presented in slot k of a word.
  function automatic logic [2:0] slot_idx(input int k);
`ifdef MUX_SEQ_MSB_FIRST_EN
    return 3'(7 - k);
`else
    return 3'(k);
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    a_din = 8'h00; a_din_valid = 1'b0;
    b_din = 8'h00; b_din_valid = 1'b0;
    #1 rst = 1'b1;
    #2;
    checks++;
    if (a_i !== 8'h00 || a_s !== 3'd0 || a_bit_valid !== 1'b0 || a_last !== 1'b0 || a_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_a: i=%h s=%0d bv=%b last=%b done=%b, required 00/0/0/0/0",
               a_i, a_s, a_bit_valid, a_last, a_done);
    end
    checks++;
    if (b_i !== 8'h00 || b_s !== 3'd0 || b_bit_valid !== 1'b0 || b_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_b: i=%h s=%0d bv=%b done=%b, required 00/0/0/0", b_i, b_s, b_bit_valid, b_done);
    end
    @(negedge clk) rst = 1'b0;
    step();
    checks++;
    if (a_din_ready !== 1'b1 || b_din_ready !== 1'b1 || a_s !== 3'd0 || a_bit_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ready_a=%b ready_b=%b s=%0d bv=%b, required 1/1/0/0",
               a_din_ready, b_din_ready, a_s, a_bit_valid);
    end
    $display("reset released");
  endtask

  task automatic test_single_word();
    logic [7:0] w;
    w = 8'hA5;
    a_din = w; a_din_valid = 1'b1;
    step();
    a_din_valid = 1'b0;
    $display("word %h accepted on a", w);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (a_s !== slot_idx(k) || a_bit_valid !== 1'b1 || a_last !== (k == 7) || a_din_ready !== (k == 7)) begin
        errors++;
        $display("FAIL single_slot%0d: s=%0d bv=%b last=%b ready=%b, required s=%0d bv=1 last=%b ready=%b",
                 k, a_s, a_bit_valid, a_last, a_din_ready, slot_idx(k), (k == 7), (k == 7));
      end
      checks++;
      if (a_i[a_s] !== w[slot_idx(k)] || a_done !== 1'b0) begin
        errors++;
        $display("FAIL single_y%0d: y=%b done=%b, required y=%b done=0", k, a_i[a_s], a_done, w[slot_idx(k)]);
      end
      step();
    end
    checks++;
    if (a_done !== 1'b1 || a_bit_valid !== 1'b0 || a_din_ready !== 1'b1 || a_last !== 1'b0) begin
      errors++;
      $display("FAIL single_done: done=%b bv=%b ready=%b last=%b, required 1/0/1/0",
               a_done, a_bit_valid, a_din_ready, a_last);
    end
    step();
    checks++;
    if (a_done !== 1'b0) begin
      errors++;
      $display("FAIL single_done_pulse: done=%b, required 0", a_done);
    end
  endtask

  task automatic test_hold_stretch();
    logic [7:0] w;
    int bv_count;
    w = 8'h0F;
    bv_count = 0;
    b_din = w; b_din_valid = 1'b1;
    step();
    b_din_valid = 1'b0;
    $display("word %h accepted on b", w);
    for (int c = 0; c < 24; c++) begin
      if (b_bit_valid === 1'b1) bv_count++;
      checks++;
      if (b_s !== slot_idx(c / 3) || b_i[b_s] !== w[slot_idx(c / 3)] || b_din_ready !== (c == 23)) begin
        errors++;
        $display("FAIL hold_cyc%0d: s=%0d y=%b ready=%b, required s=%0d y=%b ready=%b",
                 c, b_s, b_i[b_s], b_din_ready, slot_idx(c / 3), w[slot_idx(c / 3)], (c == 23));
      end
      step();
    end
    checks++;
    if (bv_count != 24 || b_done !== 1'b1 || b_bit_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_end: bv_cycles=%0d done=%b bv=%b, required 24/1/0", bv_count, b_done, b_bit_valid);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [7:0] w0, w1, w;
    int done_count;
    w0 = 8'h81; w1 = 8'h7E;
    done_count = 0;
    a_din = w0; a_din_valid = 1'b1;
    step();
    a_din = w1;
    $display("word %h accepted on a", w0);
    for (int c = 0; c < 16; c++) begin
      w = (c < 8) ? w0 : w1;
      if (a_done === 1'b1) done_count++;
      checks++;
      if (a_i !== w || a_s !== slot_idx(c % 8) || a_bit_valid !== 1'b1 || a_din_ready !== ((c % 8) == 7)) begin
        errors++;
        $display("FAIL b2b_cyc%0d: i=%h s=%0d bv=%b ready=%b, required i=%h s=%0d bv=1 ready=%b",
                 c, a_i, a_s, a_bit_valid, a_din_ready, w, slot_idx(c % 8), ((c % 8) == 7));
      end
      checks++;
      if (a_done !== (c == 8)) begin
        errors++;
        $display("FAIL b2b_done%0d: done=%b, required %b", c, a_done, (c == 8));
      end
      step();
      if (c == 7) begin
        a_din_valid = 1'b0;
        $display("word %h accepted on a", w1);
      end
    end
    if (a_done === 1'b1) done_count++;
    checks++;
    if (done_count != 2 || a_bit_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_total: done_pulses=%0d bv=%b, required 2/0", done_count, a_bit_valid);
    end
    step();
  endtask

  task automatic test_backpressure();
    logic [7:0] w0, w1;
    w0 = 8'h3C; w1 = 8'hFF;
    a_din = w0; a_din_valid = 1'b1;
    step();
    a_din_valid = 1'b0;
    $display("word %h accepted on a", w0);
    for (int k = 0; k < 8; k++) begin
      if (k == 3) begin
        a_din = w1; a_din_valid = 1'b1;
      end
      checks++;
      if (a_i !== w0 || a_s !== slot_idx(k) || a_din_ready !== (k == 7)) begin
        errors++;
        $display("FAIL bp_slot%0d: i=%h s=%0d ready=%b, required i=%h s=%0d ready=%b",
                 k, a_i, a_s, a_din_ready, w0, slot_idx(k), (k == 7));
      end
      step();
    end
    a_din_valid = 1'b0;
    $display("word %h accepted on a", w1);
    checks++;
    if (a_i !== w1 || a_s !== slot_idx(0) || a_bit_valid !== 1'b1 || a_done !== 1'b1) begin
      errors++;
      $display("FAIL bp_accept: i=%h s=%0d bv=%b done=%b, required i=%h s=%0d bv=1 done=1",
               a_i, a_s, a_bit_valid, a_done, w1, slot_idx(0));
    end
    for (int k = 0; k < 9; k++) step();
    checks++;
    if (a_bit_valid !== 1'b0 || a_din_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_idle: bv=%b ready=%b, required 0/1", a_bit_valid, a_din_ready);
    end
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] w;
    w = 8'h5A;
    a_din = w; a_din_valid = 1'b1;
    step();
    a_din_valid = 1'b0;
    $display("word %h accepted on a", w);
    for (int k = 0; k < 4; k++) step();
    checks++;
    if (a_s !== slot_idx(4) || a_bit_valid !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre: s=%0d bv=%b, required s=%0d bv=1", a_s, a_bit_valid, slot_idx(4));
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if (a_i !== 8'h00 || a_s !== 3'd0 || a_bit_valid !== 1'b0 || a_last !== 1'b0 || a_done !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async: i=%h s=%0d bv=%b last=%b done=%b, required 00/0/0/0/0",
               a_i, a_s, a_bit_valid, a_last, a_done);
    end
    @(negedge clk) rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      checks++;
      if (a_done !== 1'b0 || a_bit_valid !== 1'b0 || a_i !== 8'h00) begin
        errors++;
        $display("FAIL rstmid_after%0d: done=%b bv=%b i=%h, required 0/0/00", k, a_done, a_bit_valid, a_i);
      end
    end
    $display("word %h aborted by reset", w);
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_hold_stretch();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_word();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
